pcie_rx_mwr_sink: RTL

PCIE_RX_MWR_SINK -- requirements
Module: pcie_rx_mwr_sink

---
 rtl/tlp_pkg.sv | 31 +++
 rtl/pcie_rx_mwr_sink_if.sv | 32 +++
 rtl/wiggle_csr.sv | 46 ++++
 rtl/pcie_rx_mwr_sink.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// tlp_pkg: shared definitions for the posted memory-write sink.
//   state_t    parser FSM states
//   FMT_MWR32  w0[15:8] fmt/type byte of a 3DW memory write
//   FMT_MWR64  w0[15:8] fmt/type byte of a 4DW memory write
//   REG_LED    DW offset of the LED register
//   REG_GPIO   DW offset of the GPIO register
//   pd_credits posted-data credit count for a TLP Length field
package tlp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DROP,
        ST_DONE
    } state_t;

    localparam logic [7:0] FMT_MWR32 = 8'h40;
    localparam logic [7:0] FMT_MWR64 = 8'h60;

    localparam logic [9:0] REG_LED  = 10'd0;
    localparam logic [9:0] REG_GPIO = 10'd1;

    // One data credit per 4 DW; Length 0 means 1024 DW, which wraps to 8'd0.
    function automatic logic [7:0] pd_credits(input logic [9:0] len);
        logic [10:0] dw;
        dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        return 8'((dw + 11'd3) >> 2);
    endfunction

endpackage

// File: rtl/pcie_rx_mwr_sink_if.sv
// pcie_rx_mwr_sink_if: 16-bit PCIe receive TLP stream.
//   rx_st        first word of a TLP
//   rx_end       last word of a TLP (may coincide with rx_st)
//   rx_data      16-bit TLP word, gap-free between rx_st and rx_end
//   rx_bar_hit   BAR match flags, valid with rx_st
//   rx_malf_tlp  malformed flag, valid with rx_end
// master drives the stream, slave consumes it.
interface pcie_rx_mwr_sink_if;

    logic        rx_st;
    logic        rx_end;
    logic [15:0] rx_data;
    logic [6:0]  rx_bar_hit;
    logic        rx_malf_tlp;

    modport master (
        output rx_st,
        output rx_end,
        output rx_data,
        output rx_bar_hit,
        output rx_malf_tlp
    );

    modport slave (
        input rx_st,
        input rx_end,
        input rx_data,
        input rx_bar_hit,
        input rx_malf_tlp
    );

endinterface

// File: rtl/wiggle_csr.sv
// wiggle_csr: LED/GPIO register file written by single-DW memory writes.
//   clk, rst  clock and synchronous active-high reset
//   we        write strobe (one cycle)
//   off       DW offset of the write
//   be        byte enables, be[i] enables wdata byte i
//   wdata     write data DW
//   led       8-bit LED register (REG_LED, byte 0)
//   gpio      24-bit GPIO register (REG_GPIO, bytes 0-2)
module wiggle_csr
    import tlp_pkg::*;
#(
    parameter logic [7:0] LED_RST = 8'hFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [9:0]  off,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [7:0]  led,
    output logic [23:0] gpio
);

    // Byte 3 has no backing register at either offset.
    logic unused_byte3;
    assign unused_byte3 = ^{be[3], wdata[31:24]};

    always_ff @(posedge clk) begin
        if (rst) begin
            led  <= LED_RST;
            gpio <= '0;
        end else if (we) begin
            if (off == REG_LED && be[0]) begin
                led <= wdata[7:0];
            end
            if (off == REG_GPIO) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (be[i]) begin
                        gpio[i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pcie_rx_mwr_sink.sv
// pcie_rx_mwr_sink: parses 3DW posted memory writes from a 16-bit RX stream,
// commits single-DW writes to wiggle_csr and returns posted credits.
//   clk, rst      clock and synchronous active-high reset
//   rx            RX TLP stream (slave modport)
//   ph_processed  one-cycle pulse: one posted-header credit returned
//   pd_processed  one-cycle pulse: posted-data credits returned
//   pd_num        data credits returned, valid with pd_processed
//   unsupported   one-cycle pulse: received TLP was not a posted write
//   wr_valid      one-cycle pulse: a register write committed
//   led, gpio     register outputs from wiggle_csr
module pcie_rx_mwr_sink
    import tlp_pkg::*;
#(
    parameter int unsigned BAR_SEL = 0,
    parameter logic [7:0]  LED_RST = 8'hFE
) (
    input  logic                clk,
    input  logic                rst,
    pcie_rx_mwr_sink_if.slave   rx,
    output logic                ph_processed,
    output logic                pd_processed,
    output logic [7:0]          pd_num,
    output logic                unsupported,
    output logic                wr_valid,
    output logic [7:0]          led,
    output logic [23:0]         gpio
);

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  idx;
    logic        posted_q, bar_q, ep_q, len_ok_q;
    logic [9:0]  len_q, off_q;
    logic [3:0]  be_q;
    logic [15:0] w6_q;

    logic        mid, act, end_cycle, cur_posted, cur_len_ok;
    logic [9:0]  cur_len;
    logic        abort, ends_posted, commit;
    logic        ph_d, pd_d, unsup_d, wr_d;
    logic [7:0]  pd_num_d;
    logic [31:0] wdata;

    // Only the selected BAR flag qualifies a write.
    logic unused_bar;
    assign unused_bar = ^rx.rx_bar_hit;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = '0;
        mid         = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_DROP);
        act         = rx.rx_st || mid;
        idx         = rx.rx_st ? 4'd0 : wcnt_q;
        end_cycle   = act && rx.rx_end;
        cur_posted  = rx.rx_st ? (rx.rx_data[15:8] == FMT_MWR32 || rx.rx_data[15:8] == FMT_MWR64)
                               : posted_q;
        // Length counts as captured on the very word that carries it.
        cur_len_ok  = (idx == 4'd1) || (!rx.rx_st && len_ok_q);
        cur_len     = (idx == 4'd1) ? rx.rx_data[9:0] : len_q;
        abort       = rx.rx_st && mid && posted_q;
        ends_posted = end_cycle && cur_posted;
        commit      = end_cycle && !rx.rx_st && state_q == ST_DATA && wcnt_q == 4'd7
                      && bar_q && len_q == 10'd1 && !ep_q && !rx.rx_malf_tlp;
        wdata       = {rx.rx_data[7:0], rx.rx_data[15:8], w6_q[7:0], w6_q[15:8]};
        ph_d        = ends_posted || abort;
        pd_d        = ends_posted || abort;
        unsup_d     = end_cycle && !cur_posted;
        wr_d        = commit && (off_q == REG_LED || off_q == REG_GPIO);
        pd_num_d    = '0;

        // A TLP ending together with an abort wins the single credit slot.
        if (ends_posted) begin
            pd_num_d = cur_len_ok ? pd_credits(cur_len) : 8'd1;
        end else if (abort) begin
            pd_num_d = len_ok_q ? pd_credits(len_q) : 8'd1;
        end

        if (act) begin
            wcnt_d = (idx < 4'd8) ? idx + 4'd1 : 4'd8;
        end

        case (state_q)
            ST_HDR:  if (idx == 4'd5) state_d = ST_DATA;
            ST_DATA: if (wcnt_q == 4'd7) state_d = ST_DROP;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        if (rx.rx_st) begin
            state_d = (rx.rx_data[15:8] == FMT_MWR32) ? ST_HDR : ST_DROP;
        end
        if (end_cycle) begin
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            posted_q <= 1'b0;
            bar_q    <= 1'b0;
            ep_q     <= 1'b0;
            len_ok_q <= 1'b0;
            len_q    <= '0;
            off_q    <= '0;
            be_q     <= '0;
            w6_q     <= '0;
        end else if (act) begin
            case (idx)
                4'd0: begin
                    posted_q <= cur_posted;
                    bar_q    <= rx.rx_bar_hit[BAR_SEL];
                    ep_q     <= 1'b0;
                    len_ok_q <= 1'b0;
                end
                4'd1: begin
                    ep_q     <= rx.rx_data[14];
                    len_q    <= rx.rx_data[9:0];
                    len_ok_q <= 1'b1;
                end
                4'd3:    be_q  <= rx.rx_data[3:0];
                4'd5:    off_q <= rx.rx_data[11:2];
                4'd6:    w6_q  <= rx.rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_processed <= 1'b0;
            pd_processed <= 1'b0;
            pd_num       <= '0;
            unsupported  <= 1'b0;
            wr_valid     <= 1'b0;
        end else begin
            ph_processed <= ph_d;
            pd_processed <= pd_d;
            pd_num       <= pd_num_d;
            unsupported  <= unsup_d;
            wr_valid     <= wr_d;
        end
    end

    wiggle_csr #(
        .LED_RST (LED_RST)
    ) u_csr (
        .clk   (clk),
        .rst   (rst),
        .we    (commit),
        .off   (off_q),
        .be    (be_q),
        .wdata (wdata),
        .led   (led),
        .gpio  (gpio)
    );

endmodule
